// File: rtl/rv_fetch.sv
// rv_fetch: RV32 instruction-fetch stage.
// Owns the PC, issues single-outstanding word reads on the instruction bus and
// presents {instr, pc, pc+4} to decode through an output slot backed by a
// one-entry skid buffer. A redirect flushes both slots. An in-flight read is
// then completed and discarded in DROP.
module rv_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stall,
   input  logic        i_pc_sel,
   input  logic [31:0] i_pc_target,
   output logic [31:0] o_bus_addr,
   output logic        o_bus_req,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_data,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_DROP = 1'b1;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        pend_q, pend_d;          // request issued, not yet acked (RUN)
   logic        started_q;               // first cycle after reset has passed
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_pc_plus4_q, out_pc_plus4_d;

   logic        bus_req;
   logic        ack_acc;
   logic        consume;
   logic        slot_free;
   logic [31:0] target;
   logic        unused_target_lsbs;

   assign target             = {i_pc_target[31:2], 2'b00};
   assign unused_target_lsbs = ^i_pc_target[1:0];

   // Bus request: DROP always holds its request until the ack; RUN requests
   // while the skid has room or a request is already on the bus.
   assign bus_req   = started_q & ((state_q == ST_DROP) | ~skid_valid_q | pend_q);
   assign ack_acc   = bus_req & i_bus_ack;
   assign consume   = out_valid_q & ~i_stall;
   assign slot_free = ~out_valid_q | consume;

   assign o_bus_req  = bus_req;
   assign o_bus_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
   assign o_valid    = out_valid_q;
   assign o_instr    = out_instr_q;
   assign o_pc       = out_pc_q;
   assign o_pc_plus4 = out_pc_plus4_q;

   // Next-state logic: redirect first, then DROP draining, then normal fetch.
   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path
      // through this block leaves it unassigned, which would infer a latch.
      state_d        = state_q;
      pc_d           = pc_q;
      drop_addr_d    = drop_addr_q;
      pend_d         = pend_q;
      skid_valid_d   = skid_valid_q;
      skid_instr_d   = skid_instr_q;
      skid_pc_d      = skid_pc_q;
      out_valid_d    = out_valid_q;
      out_instr_d    = out_instr_q;
      out_pc_d       = out_pc_q;
      out_pc_plus4_d = out_pc_plus4_q;

      if (i_pc_sel) begin
         pc_d         = target;
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         pend_d       = 1'b0;
         if (bus_req && !i_bus_ack) begin
            // The in-flight read must finish at its original address.
            state_d     = ST_DROP;
            drop_addr_d = o_bus_addr;
         end else begin
            state_d = ST_RUN;
         end
      end else if (state_q == ST_DROP) begin
         if (ack_acc) begin
            state_d = ST_RUN;
         end
      end else begin
         pend_d = bus_req & ~i_bus_ack;
         if (ack_acc) begin
            pc_d = pc_q + 32'd4;
         end
         if (slot_free) begin
            if (skid_valid_q) begin
               // Skid drains first to keep program order.
               out_valid_d    = 1'b1;
               out_instr_d    = skid_instr_q;
               out_pc_d       = skid_pc_q;
               out_pc_plus4_d = skid_pc_q + 32'd4;
               skid_valid_d   = ack_acc;
               if (ack_acc) begin
                  skid_instr_d = i_bus_data;
                  skid_pc_d    = pc_q;
               end
            end else if (ack_acc) begin
               out_valid_d    = 1'b1;
               out_instr_d    = i_bus_data;
               out_pc_d       = pc_q;
               out_pc_plus4_d = pc_q + 32'd4;
            end else begin
               out_valid_d = 1'b0;
            end
         end else if (ack_acc) begin
            skid_valid_d = 1'b1;
            skid_instr_d = i_bus_data;
            skid_pc_d    = pc_q;
         end
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!i_reset_n) begin
         state_q        <= ST_RUN;
         pc_q           <= RESET_VECTOR;
         drop_addr_q    <= RESET_VECTOR;
         pend_q         <= 1'b0;
         started_q      <= 1'b0;
         skid_valid_q   <= 1'b0;
         out_valid_q    <= 1'b0;
         out_instr_q    <= NOP;
         out_pc_q       <= RESET_VECTOR;
         out_pc_plus4_q <= RESET_VECTOR + 32'd4;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         drop_addr_q    <= drop_addr_d;
         pend_q         <= pend_d;
         started_q      <= 1'b1;
         skid_valid_q   <= skid_valid_d;
         out_valid_q    <= out_valid_d;
         out_instr_q    <= out_instr_d;
         out_pc_q       <= out_pc_d;
         out_pc_plus4_q <= out_pc_plus4_d;
      end
   end

   // Skid payload registers.
   always_ff @(posedge i_clk) begin
      // NOTE: the skid payload is not reset; skid_valid_q alone qualifies it.
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
   end

endmodule

// File: tb/tb_rv_fetch.sv
// tb_rv_fetch: randomized scoreboard bench for rv_fetch.
// The bus slave answers with configurable latency from a synthetic memory.
// The reference model holds every accepted-but-unconsumed word in a queue.
// It checks delivery order, the request rules and the redirect/drop behaviour.
module tb_rv_fetch;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        pc_sel = 1'b0;
   logic [31:0] target = 32'h0;
   logic [31:0] bus_addr;
   logic        bus_req;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_data = 32'h0;
   logic        o_valid;
   logic [31:0] o_instr, o_pc, o_pc_plus4;

   always #5 clk = ~clk;

   rv_fetch #(.RESET_VECTOR(RV)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_stall     (stall),
      .i_pc_sel    (pc_sel),
      .i_pc_target (target),
      .o_bus_addr  (bus_addr),
      .o_bus_req   (bus_req),
      .i_bus_ack   (bus_ack),
      .i_bus_data  (bus_data),
      .o_valid     (o_valid),
      .o_instr     (o_instr),
      .o_pc        (o_pc),
      .o_pc_plus4  (o_pc_plus4)
   );

   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0013_C0DE;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- bus slave ----------------
   int          lat_mode = 0;          // <0: random 0..3, else fixed wait cycles
   logic [31:0] slow_addr = 32'hFFFF_FFFF;
   int          slow_lat = 0;
   bit          spurious_en = 1'b0;
   bit          busy = 1'b0;
   int          left = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus_data = mem_word(bus_addr);
         if (!rst_n) begin
            busy    = 1'b0;
            bus_ack = 1'b0;
         end else if (bus_req) begin
            if (!busy) begin
               busy = 1'b1;
               if (bus_addr == slow_addr) left = slow_lat;
               else if (lat_mode < 0)     left = $urandom_range(0, 3);
               else                       left = lat_mode;
            end
            if (left == 0) begin
               bus_ack = 1'b1;
               busy    = 1'b0;
            end else begin
               bus_ack = 1'b0;
               left--;
            end
         end else begin
            busy    = 1'b0;
            bus_ack = spurious_en && ($urandom_range(0, 7) == 0);
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } word_t;

   word_t       q[$];
   logic [31:0] ref_pc = RV;
   logic [31:0] drop_addr = 32'h0;
   logic [31:0] prev_addr = 32'h0;
   bit          dropping = 1'b0;
   bit          started = 1'b0;
   bit          prev_hold = 1'b0;
   bit          armed = 1'b0;
   bit          in_reset = 1'b0;
   bit          acc;
   int          consumed = 0;

   // Sampled on the falling edge: first check the state left by the last
   // rising edge, then fold the coming rising edge into the model.
   always @(negedge clk) begin
      if (armed) begin
         if (in_reset) begin
            check("rst_valid", o_valid, 0);
            check("rst_req", bus_req, 0);
            check("rst_instr", o_instr, NOP);
            check("rst_pc", o_pc, RV);
            check("rst_pc_plus4", o_pc_plus4, RV + 32'd4);
         end else begin
            check("req", bus_req, started && (prev_hold || q.size() < 2));
            if (prev_hold) check("addr_hold", bus_addr, prev_addr);
            check("valid", o_valid, q.size() > 0);
            if (o_valid && q.size() > 0) begin
               check("out_pc", o_pc, q[0].pc);
               check("out_instr", o_instr, q[0].instr);
               check("out_pc_plus4", o_pc_plus4, q[0].pc + 32'd4);
            end
         end
      end

      if (!rst_n) begin
         armed     = 1'b1;
         in_reset  = 1'b1;
         q.delete();
         ref_pc    = RV;
         dropping  = 1'b0;
         started   = 1'b0;
         prev_hold = 1'b0;
      end else if (armed) begin
         in_reset = 1'b0;
         acc      = bus_req && bus_ack;
         if (pc_sel) begin
            if (acc) check("addr_redir_ack", bus_addr, dropping ? drop_addr : ref_pc);
            if (bus_req && !bus_ack) begin
               if (!dropping) drop_addr = bus_addr;
               dropping = 1'b1;
            end else begin
               dropping = 1'b0;
            end
            q.delete();
            ref_pc = {target[31:2], 2'b00};
         end else begin
            if (o_valid && !stall && q.size() > 0) begin
               void'(q.pop_front());
               consumed++;
            end
            if (acc) begin
               if (dropping) begin
                  check("addr_drop", bus_addr, drop_addr);
                  dropping = 1'b0;
               end else begin
                  check("addr", bus_addr, ref_pc);
                  q.push_back('{ref_pc, mem_word(ref_pc)});
                  ref_pc = ref_pc + 32'd4;
               end
            end
         end
         started   = 1'b1;
         prev_hold = bus_req && !bus_ack;
         prev_addr = bus_addr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_cons(input int n, input int budget);
      int tgt;
      int k;
      tgt = consumed + n;
      k = 0;
      while (consumed < tgt && k < budget) begin
         step();
         k++;
      end
      check("progress", consumed >= tgt, 1);
   endtask

   task automatic wait_req_addr(input logic [31:0] a, input int budget);
      int k;
      k = 0;
      while (!(bus_req && bus_addr == a) && k < budget) begin
         step();
         k++;
      end
      check("reach_addr", bus_req && bus_addr == a, 1);
   endtask

   task automatic redirect(input logic [31:0] t);
      pc_sel = 1'b1;
      target = t;
      step();
      pc_sel = 1'b0;
   endtask

   initial begin
      // Reset release with zero-wait bus.
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      wait_cons(8, 50);

      // Stall while the bus keeps acking: slot + skid fill, req drops.
      stall = 1'b1;
      repeat (4) step();
      stall = 1'b0;
      wait_cons(6, 50);

      // Redirect while the read of 0x20 waits three cycles.
      redirect(32'h0000_0010);
      slow_addr = 32'h0000_0020;
      slow_lat  = 3;
      wait_req_addr(32'h0000_0020, 50);
      redirect(32'h0000_0100);
      wait_cons(4, 50);
      slow_addr = 32'hFFFF_FFFF;

      // Redirect coincident with a zero-wait ack; low target bits ignored.
      wait_cons(2, 20);
      redirect(32'h0000_0103);
      wait_cons(3, 30);

      // Redirect with skid full.
      stall = 1'b1;
      repeat (5) step();
      redirect(32'h0000_0200);
      stall = 1'b0;
      wait_cons(3, 30);

      // PC wrap.
      redirect(32'hFFFF_FFFC);
      wait_cons(3, 30);

      // Reset with skid full.
      stall = 1'b1;
      repeat (5) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      stall = 1'b0;
      wait_cons(3, 30);

      // Reset in the middle of DROP.
      lat_mode = 6;
      wait_cons(1, 40);
      wait_req_addr(bus_addr, 20);
      redirect(32'h0000_0300);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      lat_mode = 0;
      wait_cons(3, 30);

      // Randomized traffic.
      lat_mode    = -1;
      spurious_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         stall  = ($urandom_range(0, 9) < 3);
         pc_sel = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0:       target = $urandom;
            1:       target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: target = $urandom_range(0, 255);
         endcase
         rst_n = ($urandom_range(0, 499) != 0);
         step();
      end
      stall  = 1'b0;
      pc_sel = 1'b0;
      rst_n  = 1'b1;
      wait_cons(4, 60);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
